// File: rtl/sram_fifo_scheduler.sv
// Circular FIFO of spill words over one single-port SRAM bank; push and pop share the port by round-robin.
// Define SRAM_FIFO_PREFETCH_EN for a first-word-fall-through output (output register plus 2-deep skid).
module sram_fifo_scheduler #(
  parameter int WORD     = 256,
  parameter int ADDR_LOG = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_init,
  input  logic                i_push,
  input  logic [WORD-1:0]     i_push_data,
  output logic                o_push_ready,
  input  logic                i_pop,
  output logic                o_pop_ready,
  output logic [WORD-1:0]     o_pop_data,
  output logic                o_pop_valid,
  output logic                o_sram_CEN,
  output logic                o_sram_WEN,
  output logic [ADDR_LOG-1:0] o_sram_A,
  output logic [WORD-1:0]     o_sram_D,
  input  logic [WORD-1:0]     i_sram_Q,
  output logic [ADDR_LOG:0]   o_count,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_busy,
  output logic [1:0]          o_state
);
  localparam int CW = ADDR_LOG + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_LOG{1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_INIT = 2'd2} state_t;

  state_t              state_q;
  logic [ADDR_LOG-1:0] wr_ptr_q, rd_ptr_q, a_q;
  logic [CW-1:0]       count_q, count_d;
  logic [WORD-1:0]     d_q;
  logic                cen_q, wen_q, last_pop_q;
  logic                blk, push_want, rd_want, push_gnt, rd_gnt, rd_access;

  // Handshake: a push (pop) transfers in any cycle where i_push && o_push_ready (i_pop && o_pop_ready);
  // ready is the combinational grant and may be high with no request, which then transfers nothing.
  assign blk          = i_init || (state_q == S_INIT);
  assign rd_access    = !cen_q && wen_q;
  assign o_full       = (count_q == DEPTH);
  assign o_empty      = (count_q == '0);
  assign push_want    = i_push && !o_full && !blk;
  assign push_gnt     = push_want && (!rd_want || last_pop_q);
  assign rd_gnt       = rd_want && (!push_want || !last_pop_q);
  assign o_push_ready = !blk && !o_full && !rd_gnt;

  assign o_sram_CEN = cen_q;
  assign o_sram_WEN = wen_q;
  assign o_sram_A   = a_q;
  assign o_sram_D   = d_q;
  assign o_count    = count_q;
  assign o_state    = state_q;

`ifdef SRAM_FIFO_PREFETCH_EN
  logic [CW-1:0]   mem_cnt_q;
  logic [WORD-1:0] fb_q [3];
  logic [1:0]      fb_hd_q, fb_tl_q, fb_cnt_q;
  logic            cap_q, consume, room;

  // Every read already issued or returning owns a slot, so the 3-entry buffer can never overflow.
  assign room        = ({1'b0, fb_cnt_q} + {2'b00, cap_q} + {2'b00, rd_access}) < 3'd3;
  assign rd_want     = (mem_cnt_q != '0) && room && !blk;
  assign o_pop_valid = (fb_cnt_q != 2'd0);
  assign o_pop_ready = o_pop_valid;
  assign consume     = i_pop && o_pop_valid && !i_init;
  assign o_pop_data  = o_pop_valid ? fb_q[fb_hd_q] : '0;
  assign o_busy      = (state_q == S_INIT) || !cen_q || cap_q;
  assign count_d     = count_q + CW'(push_gnt) - CW'(consume);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cnt_q <= '0;
      fb_hd_q   <= 2'd0;
      fb_tl_q   <= 2'd0;
      fb_cnt_q  <= 2'd0;
      cap_q     <= 1'b0;
    end else if (i_init) begin
      mem_cnt_q <= '0;
      fb_hd_q   <= 2'd0;
      fb_tl_q   <= 2'd0;
      fb_cnt_q  <= 2'd0;
      cap_q     <= 1'b0;
    end else begin
      mem_cnt_q <= mem_cnt_q + CW'(push_gnt) - CW'(rd_gnt);
      cap_q     <= rd_access;
      if (cap_q) fb_tl_q <= (fb_tl_q == 2'd2) ? 2'd0 : fb_tl_q + 2'd1;
      if (consume) fb_hd_q <= (fb_hd_q == 2'd2) ? 2'd0 : fb_hd_q + 2'd1;
      fb_cnt_q <= fb_cnt_q + {1'b0, cap_q} - {1'b0, consume};
    end
  end

  always_ff @(posedge clk) begin
    if (cap_q) fb_q[fb_tl_q] <= i_sram_Q;
  end
`else
  logic pop_valid_q;

  assign rd_want     = i_pop && !o_empty && !blk;
  assign o_pop_ready = !blk && !o_empty && !push_gnt;
  assign o_pop_valid = pop_valid_q;
  // The macro drives Q in the cycle after its access; pass it through only while the pulse is up.
  assign o_pop_data  = pop_valid_q ? i_sram_Q : '0;
  assign o_busy      = (state_q == S_INIT) || !cen_q;
  assign count_d     = count_q + CW'(push_gnt) - CW'(rd_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pop_valid_q <= 1'b0;
    else        pop_valid_q <= rd_access && !i_init;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cen_q      <= 1'b1;
      wen_q      <= 1'b1;
      a_q        <= '0;
      d_q        <= '0;
      last_pop_q <= 1'b1;
    end else if (i_init) begin
      state_q  <= S_INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cen_q    <= 1'b1;
    end else begin
      count_q <= count_d;
      cen_q   <= !(push_gnt || rd_gnt);
      if (push_gnt) begin
        wen_q      <= 1'b0;
        a_q        <= wr_ptr_q;
        d_q        <= i_push_data;
        wr_ptr_q   <= wr_ptr_q + ADDR_LOG'(1);
        last_pop_q <= 1'b0;
      end else if (rd_gnt) begin
        wen_q      <= 1'b1;
        a_q        <= rd_ptr_q;
        rd_ptr_q   <= rd_ptr_q + ADDR_LOG'(1);
        last_pop_q <= 1'b1;
      end
      case (state_q)
        S_INIT:   state_q <= S_IDLE;
        S_IDLE:   if (push_gnt || rd_gnt) state_q <= S_ACTIVE;
        S_ACTIVE: if (count_q == '0 && cen_q && !(push_gnt || rd_gnt)) state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_fifo_scheduler.sv
// Directed bench for sram_fifo_scheduler with a behavioural SRAM and a queue-based scoreboard.
module tb_sram_fifo_scheduler;
  localparam int WORD  = 256;
  localparam int AL    = 10;
  localparam int DEPTH = 1 << AL;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd2;

  typedef struct packed {
    logic          wen;
    logic [AL-1:0] a;
    logic [WORD-1:0] d;
    int            due;
  } cmd_t;

  logic            clk, rst_n, i_init, i_push, i_pop;
  logic [WORD-1:0] i_push_data, o_pop_data, o_sram_D, i_sram_Q;
  logic            o_push_ready, o_pop_ready, o_pop_valid, o_sram_CEN, o_sram_WEN;
  logic            o_full, o_empty, o_busy;
  logic [AL-1:0]   o_sram_A;
  logic [AL:0]     o_count;
  logic [1:0]      o_state;

  logic [WORD-1:0] mem [DEPTH];
  logic [WORD-1:0] model_q[$];
  logic [WORD-1:0] exp_q[$];
  int              due_q[$];
  cmd_t            cmd_q[$];
  logic [AL-1:0]   mwr, mrd;
  int              total = 0;
  int              bad = 0;
  int              cyc = 0;
  bit              mon_en = 0;
  logic [31:0]     seq;

  sram_fifo_scheduler #(.WORD(WORD), .ADDR_LOG(AL)) dut (
    .clk(clk), .rst_n(rst_n), .i_init(i_init),
    .i_push(i_push), .i_push_data(i_push_data), .o_push_ready(o_push_ready),
    .i_pop(i_pop), .o_pop_ready(o_pop_ready), .o_pop_data(o_pop_data), .o_pop_valid(o_pop_valid),
    .o_sram_CEN(o_sram_CEN), .o_sram_WEN(o_sram_WEN), .o_sram_A(o_sram_A), .o_sram_D(o_sram_D),
    .i_sram_Q(i_sram_Q), .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
    .o_busy(o_busy), .o_state(o_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous single-port SRAM: Q is valid the cycle after a read access
  always @(posedge clk) begin
    if (!o_sram_CEN) begin
      if (!o_sram_WEN) mem[o_sram_A] <= o_sram_D;
      else             i_sram_Q <= mem[o_sram_A];
    end
  end

  task automatic check(input string nm, input logic [WORD-1:0] act, input logic [WORD-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_rst(input string p);
    check({p, "_cen"}, o_sram_CEN, 1);
    check({p, "_wen"}, o_sram_WEN, 1);
    check({p, "_a"}, o_sram_A, 0);
    check({p, "_d"}, o_sram_D, 0);
    check({p, "_valid"}, o_pop_valid, 0);
    check({p, "_data"}, o_pop_data, 0);
    check({p, "_count"}, o_count, 0);
    check({p, "_busy"}, o_busy, 0);
    check({p, "_empty"}, o_empty, 1);
    check({p, "_full"}, o_full, 0);
    check({p, "_state"}, o_state, ST_IDLE);
  endtask

  // driver tasks: inputs change only at posedge+1
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [WORD-1:0] d);
    int n = 0;
    i_push = 1'b1;
    i_push_data = d;
    @(negedge clk);
    while (!o_push_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("push_wait", o_push_ready, 1);
    step();
    i_push = 1'b0;
  endtask

  task automatic pop_one();
    int n = 0;
    i_pop = 1'b1;
    @(negedge clk);
    while (!o_pop_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("pop_wait", o_pop_ready, 1);
    step();
    i_pop = 1'b0;
  endtask

  // scoreboard monitor: outputs checked against queues, then this cycle's handshakes recorded
  always @(negedge clk) begin : monitor
    cmd_t c;
    logic [WORD-1:0] w;
    int dv;
    if (mon_en && rst_n) begin
      if (o_pop_valid) begin
        if (due_q.size() == 0) begin
          check("pop_unexpected", o_pop_valid, 0);
        end else begin
          w  = exp_q.pop_front();
          dv = due_q.pop_front();
          check("pop_data", o_pop_data, w);
          check("pop_latency", cyc, dv);
        end
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
        check("pop_missing", o_pop_valid, 1);
        w  = exp_q.pop_front();
        dv = due_q.pop_front();
      end
      if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
        c = cmd_q.pop_front();
        check("sram_cen", o_sram_CEN, 0);
        check("sram_wen", o_sram_WEN, c.wen);
        check("sram_a", o_sram_A, c.a);
        if (!c.wen) check("sram_d", o_sram_D, c.d);
      end else begin
        check("sram_idle_cen", o_sram_CEN, 1);
      end
      check("count", o_count, model_q.size());
      check("full", o_full, model_q.size() == DEPTH);
      check("empty", o_empty, model_q.size() == 0);
      if (i_init) begin
        model_q.delete();
        exp_q.delete();
        due_q.delete();
        cmd_q.delete();
        mwr = '0;
        mrd = '0;
      end else begin
        if ((i_push && o_push_ready) || (i_pop && o_pop_ready))
          check("single_grant", (i_push && o_push_ready) && (i_pop && o_pop_ready), 0);
        if (i_push && o_push_ready) begin
          check("push_not_full", model_q.size() < DEPTH, 1);
          model_q.push_back(i_push_data);
          cmd_q.push_back('{wen: 1'b0, a: mwr, d: i_push_data, due: cyc + 1});
          mwr = mwr + 1'b1;
        end else if (i_pop && o_pop_ready) begin
          check("pop_not_empty", model_q.size() > 0, 1);
          if (model_q.size() > 0) begin
            exp_q.push_back(model_q.pop_front());
            due_q.push_back(cyc + 2);
            cmd_q.push_back('{wen: 1'b1, a: mrd, d: '0, due: cyc + 1});
            mrd = mrd + 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : stimulus
    bit expect_pop, adv;
    int n;
    i_init = 1'b0; i_push = 1'b0; i_pop = 1'b0; i_push_data = '0;
    rst_n = 1'b0; mwr = '0; mrd = '0; seq = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    check_rst("rst");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // three pushes of byte-filled words
    for (int k = 1; k <= 3; k++) push_one({32{8'(k)}});
    @(negedge clk);
    check("t1_count", o_count, 3);
    check("t1_empty", o_empty, 0);
    step();

    // three back-to-back pops, then settle to idle
    for (int k = 0; k < 3; k++) pop_one();
    @(negedge clk);
    check("t2_busy_access", o_busy, 1);
    @(negedge clk);
    check("t2_last_valid", o_pop_valid, 1);
    check("t2_last_data", o_pop_data, {32{8'h03}});
    @(negedge clk);
    check("t2_busy_idle", o_busy, 0);
    check("t2_state", o_state, ST_IDLE);
    check("t2_count", o_count, 0);
    step();

    // count 5, then push and pop contend for 100 cycles
    for (int k = 0; k < 5; k++) begin
      seq++;
      push_one({8{seq}});
    end
    seq++;
    i_push = 1'b1; i_pop = 1'b1; i_push_data = {8{seq}};
    expect_pop = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check("alt_grant", {o_push_ready, o_pop_ready}, expect_pop ? 2'b01 : 2'b10);
      adv = o_push_ready;
      expect_pop = !expect_pop;
      step();
      if (adv) begin
        seq++;
        i_push_data = {8{seq}};
      end
    end
    i_push = 1'b0; i_pop = 1'b0;
    repeat (3) step();

    // init right after a pop grant with 7 stored
    for (int k = 0; k < 2; k++) begin
      seq++;
      push_one({8{seq}});
    end
    pop_one();
    i_init = 1'b1;
    @(negedge clk);
    step();
    i_init = 1'b0;
    @(negedge clk);
    check("init_busy", o_busy, 1);
    check("init_state", o_state, ST_INIT);
    check("init_count", o_count, 0);
    check("init_valid", o_pop_valid, 0);
    @(negedge clk);
    check("post_init_busy", o_busy, 0);
    check("post_init_state", o_state, ST_IDLE);
    check("post_init_cen", o_sram_CEN, 1);
    check("post_init_count", o_count, 0);
    step();

    // fill to capacity, wrap the write pointer, then drain across the wrap
    for (int k = 0; k < DEPTH; k++) push_one({8{32'hA000_0000 | 32'(k)}});
    i_push = 1'b1;
    i_push_data = {8{32'h5EED_0001}};
    @(negedge clk);
    check("full_flag", o_full, 1);
    check("full_push_ready", o_push_ready, 0);
    check("full_count", o_count, DEPTH);
    step();
    pop_one();
    @(negedge clk);
    check("wrap_push_ready", o_push_ready, 1);
    step();
    i_push = 1'b0;
    @(negedge clk);
    check("wrap_a", o_sram_A, 0);
    check("wrap_wen", o_sram_WEN, 0);
    check("wrap_full", o_full, 1);
    step();
    i_pop = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_empty && n < 1100) begin
      n++;
      @(negedge clk);
    end
    check("drain_empty", o_empty, 1);
    step();
    i_pop = 1'b0;
    repeat (4) step();
    check("drain_done", exp_q.size(), 0);

    // asynchronous reset in the middle of a push burst
    i_push = 1'b1;
    i_push_data = {8{32'hC0DE_0001}};
    step();
    step();
    #2;
    check("burst_cen", o_sram_CEN, 0);
    mon_en = 1'b0;
    rst_n = 1'b0;
    i_push = 1'b0;
    #1;
    check_rst("arst");
    model_q.delete(); exp_q.delete(); due_q.delete(); cmd_q.delete();
    mwr = '0; mrd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;
    push_one({8{32'hBEEF_0001}});
    push_one({8{32'hBEEF_0002}});
    pop_one();
    pop_one();
    repeat (4) step();

    check("final_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
